// File: rtl/tanh_grad.sv
// Local gradient of a tanh activation in Q(WIDTH-FL).FL: d = g * (1 - y^2).
// Three-stage stall-together pipeline with valid/ready handshakes on both sides.
module tanh_grad #(
  parameter int WIDTH = 32,
  parameter int FL    = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] g_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] d_out,
  output logic                    clamp_out
);

  localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-FL-1){1'b0}}, 1'b1, {FL{1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

  function automatic logic signed [WIDTH-1:0] clamp_unit(input logic signed [WIDTH-1:0] v);
    if (v > ONE)          return ONE;
    else if (v < NEG_ONE) return NEG_ONE;
    else                  return v;
  endfunction

  function automatic logic out_of_range(input logic signed [WIDTH-1:0] v);
    return (v > ONE) || (v < NEG_ONE);
  endfunction

  // Full-precision product, arithmetic shift by FL (truncation toward -inf).
  // Callers guarantee one operand magnitude <= ONE, so the result fits WIDTH.
  function automatic logic signed [WIDTH-1:0] mul_trunc(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;
    logic signed [2*WIDTH-1:0] p;
    ax = {{WIDTH{a[WIDTH-1]}}, a};
    bx = {{WIDTH{b[WIDTH-1]}}, b};
    p  = ax * bx;
    return p[FL +: WIDTH];
  endfunction

  logic                    en;
  logic signed [WIDTH-1:0] yc_p0;
  logic signed [WIDTH-1:0] g_p0;
  logic                    c_p0;
  logic                    vld_p0;
  logic signed [WIDTH-1:0] s_p1;
  logic signed [WIDTH-1:0] g_p1;
  logic                    c_p1;
  logic                    vld_p1;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
    end
  end

  // Stage 0: clamp y into [-ONE, +ONE], capture g
  always_ff @(posedge clk) begin
    if (en) begin
      yc_p0 <= clamp_unit(y_in);
      g_p0  <= g_in;
      c_p0  <= out_of_range(y_in);
    end
  end

  // Stage 1: s = ONE - y^2, always within [0, ONE]
  always_ff @(posedge clk) begin
    if (en) begin
      s_p1 <= ONE - mul_trunc(yc_p0, yc_p0);
      g_p1 <= g_p0;
      c_p1 <= c_p0;
    end
  end

  // Stage 2: d = g * s; outputs are cleared by reset so nothing stale is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out     <= '0;
      clamp_out <= 1'b0;
    end else if (en) begin
      d_out     <= mul_trunc(g_p1, s_p1);
      clamp_out <= c_p1;
    end
  end

endmodule

// File: tb/tb_tanh_grad.sv
// Directed and randomized checks of tanh_grad against hand values and a Q8.24 model.
module tb_tanh_grad;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y_in;
  logic [31:0] g_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic        clamp_out;

  int checks;
  int failures;

  tanh_grad #(.WIDTH(32), .FL(24)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in), .g_in(g_in),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .clamp_out(clamp_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] y, input logic [31:0] g);
    logic signed [31:0] ys, gs, yc, s, one;
    logic signed [63:0] p, q;
    logic c;
    one = 32'sh01000000;
    ys = y;
    gs = g;
    c  = (ys > one) || (ys < -one);
    yc = (ys > one) ? one : ((ys < -one) ? -one : ys);
    p  = 64'(yc) * 64'(yc);
    s  = one - p[55:24];
    q  = 64'(gs) * 64'(s);
    return {c, q[55:24]};
  endfunction

  // One isolated sample: accept, two empty cycles, then the result.
  task automatic send_one(input string tag, input logic [31:0] y, input logic [31:0] g,
                          input logic [31:0] exp_d, input logic exp_c);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; y_in = y; g_in = g;
    #1 chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1 chk({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1 chk({tag, "_lat3_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_d"}, d_out, exp_d);
    chk({tag, "_clamp"}, {31'd0, clamp_out}, {31'd0, exp_c});
  endtask

  // mode 0: full rate; mode 1: out_ready low for 5 cycles mid-stream; mode 2: random
  task automatic run_stream(input string tag, input int n, input int mode);
    logic [32:0] exq[$];
    logic [32:0] e;
    logic [31:0] prev_d;
    logic        prev_c;
    logic        prev_hold;
    int sent, got, cyc, first_acc;
    sent = 0; got = 0; cyc = 0; first_acc = -1; prev_hold = 1'b0;
    prev_d = '0; prev_c = 1'b0;
    while ((got < n) && (cyc < n * 10 + 100)) begin
      @(negedge clk);
      if (mode == 2) begin
        in_valid  = (sent < n) && ($urandom_range(1, 0) == 1);
        out_ready = ($urandom_range(1, 0) == 1);
        y_in = $urandom_range(32'h04000000, 0) - 32'h02000000;
        g_in = $urandom_range(32'h08000000, 0) - 32'h04000000;
      end else begin
        in_valid  = (sent < n);
        out_ready = (mode == 0) || !((cyc >= 6) && (cyc < 11));
        y_in = 32'(sent) * 32'h00300000 - 32'h00A00000;
        g_in = 32'h01000000 + 32'(sent) * 32'h00110000;
      end
      #1;
      if (prev_hold) begin
        chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_hold_d"}, d_out, prev_d);
        chk({tag, "_hold_clamp"}, {31'd0, clamp_out}, {31'd0, prev_c});
      end
      if ((mode == 1) && out_valid && !out_ready)
        chk({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exq.size() == 0) begin
          chk({tag, "_extra_output"}, 32'd1, 32'd0);
        end else begin
          e = exq.pop_front();
          chk({tag, "_d"}, d_out, e[31:0]);
          chk({tag, "_clamp"}, {31'd0, clamp_out}, {31'd0, e[32]});
          if (mode == 0) chk({tag, "_emit_cycle"}, 32'(cyc), 32'(first_acc + 3 + got));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exq.push_back(model(y_in, g_in));
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      prev_hold = out_valid && !out_ready;
      prev_d = d_out;
      prev_c = clamp_out;
      cyc++;
    end
    chk({tag, "_out_count"}, 32'(got), 32'(n));
    chk({tag, "_acc_count"}, 32'(sent), 32'(n));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    y_in = 32'h00800000; g_in = 32'h01000000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d_out", d_out, 32'd0);
    chk("rst_clamp", {31'd0, clamp_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);

    send_one("y0_g1",      32'h00000000, 32'h01000000, 32'h01000000, 1'b0);
    send_one("yhalf_g1",   32'h00800000, 32'h01000000, 32'h00C00000, 1'b0);
    send_one("ynhalf_gn2", 32'hFF800000, 32'hFE000000, 32'hFE800000, 1'b0);
    send_one("yone_gmax",  32'h01000000, 32'h7FFFFFFF, 32'h00000000, 1'b0);
    send_one("ynone_g1",   32'hFF000000, 32'h01000000, 32'h00000000, 1'b0);
    send_one("y1p5_clamp", 32'h01800000, 32'h01000000, 32'h00000000, 1'b1);
    send_one("yn3_clamp",  32'hFD000000, 32'h00500000, 32'h00000000, 1'b1);
    send_one("y0_gmin",    32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
    send_one("trunc_neg",  32'h00800000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    run_stream("b2b", 8, 0);
    run_stream("stall", 12, 1);
    run_stream("rand", 1000, 2);

    // Fill the pipe with three samples, hold them, then reset mid-flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    y_in = 32'h00400000; g_in = 32'h00200000;
    repeat (3) @(negedge clk);
    #1;
    chk("flight_full_valid", {31'd0, out_valid}, 32'd1);
    chk("flight_full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("flight_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("flight_rst_d", d_out, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("flight_no_stale", {31'd0, out_valid}, 32'd0);
    end
    send_one("post_flight", 32'h00000000, 32'h01000000, 32'h01000000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
